dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_arbiter_if.sv | 53 +++++
 rtl/dmem_rr_pick.sv | 19 +
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and access-size codes for the data-memory arbiter
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [1:0] LS_BYTE = 2'd0;
   localparam logic [1:0] LS_HALF = 2'd1;
   localparam logic [1:0] LS_WORD = 2'd2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester ports and memory-side bus of dmem_arbiter
interface dmem_arbiter_if;
   import dmem_pkg::*;

   logic        r0_req;
   logic        r0_we;
   logic [31:0] r0_addr;
   logic [31:0] r0_wdata;
   logic [1:0]  r0_size;
   logic        r0_sext;
   logic        r0_ack;
   logic        r0_err;
   logic [31:0] r0_rdata;

   logic        r1_req;
   logic        r1_we;
   logic [31:0] r1_addr;
   logic [31:0] r1_wdata;
   logic [1:0]  r1_size;
   logic        r1_sext;
   logic        r1_ack;
   logic        r1_err;
   logic [31:0] r1_rdata;

   logic [31:0] mem_address;
   logic [31:0] mem_writedata;
   logic [1:0]  mem_lscontrol;
   logic        mem_sign_extend;
   logic        mem_memread;
   logic        mem_memwrite;
   logic [31:0] mem_readdata;

   modport slave (
      input  r0_req, r0_we, r0_addr, r0_wdata, r0_size, r0_sext,
      output r0_ack, r0_err, r0_rdata,
      input  r1_req, r1_we, r1_addr, r1_wdata, r1_size, r1_sext,
      output r1_ack, r1_err, r1_rdata,
      output mem_address, mem_writedata, mem_lscontrol, mem_sign_extend,
      output mem_memread, mem_memwrite,
      input  mem_readdata
   );

   modport master (
      output r0_req, r0_we, r0_addr, r0_wdata, r0_size, r0_sext,
      input  r0_ack, r0_err, r0_rdata,
      output r1_req, r1_we, r1_addr, r1_wdata, r1_size, r1_sext,
      input  r1_ack, r1_err, r1_rdata,
      input  mem_address, mem_writedata, mem_lscontrol, mem_sign_extend,
      input  mem_memread, mem_memwrite,
      output mem_readdata
   );

endinterface

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - two-way round-robin pick; on a tie the requester not granted last wins
module dmem_rr_pick
   import dmem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant
);

   always_comb begin
      grant = 1'b0;
      if (req == 2'b11) begin
         grant = ~last;
      end else begin
         grant = req[1];
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter in front of a single-port data memory
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int MEM_BYTES = 32768
) (
   input logic           clock,
   input logic           reset_n,
   dmem_arbiter_if.slave bus
);

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        win_q, win_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  size_q, size_d;
   logic        sext_q, sext_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   logic        grant;
   logic        any_req;
   logic        sel_we;
   logic        sel_sext;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [1:0]  sel_size;
   logic        illegal;

   dmem_rr_pick u_pick (
      .req   ({bus.r1_req, bus.r0_req}),
      .last  (last_q),
      .grant (grant)
   );

   always_comb begin
      any_req   = bus.r0_req | bus.r1_req;
      sel_we    = grant ? bus.r1_we    : bus.r0_we;
      sel_sext  = grant ? bus.r1_sext  : bus.r0_sext;
      sel_addr  = grant ? bus.r1_addr  : bus.r0_addr;
      sel_wdata = grant ? bus.r1_wdata : bus.r0_wdata;
      sel_size  = grant ? bus.r1_size  : bus.r0_size;
      illegal   = (sel_size > LS_WORD)
               || ((sel_size == LS_HALF) && sel_addr[0])
               || ((sel_size == LS_WORD) && (sel_addr[1:0] != 2'b00))
               || (sel_addr >= MEM_LIMIT);
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      win_d   = win_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      sext_d  = sext_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               win_d   = grant;
               last_d  = grant;
               we_d    = sel_we;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               size_d  = sel_size;
               sext_d  = sel_sext;
               err_d   = illegal;
               rdata_d = 32'd0;
               state_d = illegal ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            // stores leave rdata at the zero loaded on grant
            if (!we_q) begin
               rdata_d = bus.mem_readdata;
            end
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         win_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         size_q  <= 2'd0;
         sext_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         win_q   <= win_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // strobes decode straight from state so reset drops them without waiting for an edge
   assign bus.mem_memwrite    = (state_q == ACCESS) &&  we_q;
   assign bus.mem_memread     = (state_q == ACCESS) && !we_q;
   assign bus.mem_address     = addr_q;
   assign bus.mem_writedata   = wdata_q;
   assign bus.mem_lscontrol   = size_q;
   assign bus.mem_sign_extend = sext_q;

   assign bus.r0_ack   = (state_q == RESP) && !win_q;
   assign bus.r1_ack   = (state_q == RESP) &&  win_q;
   assign bus.r0_err   = bus.r0_ack && err_q;
   assign bus.r1_err   = bus.r1_ack && err_q;
   assign bus.r0_rdata = bus.r0_ack ? rdata_q : 32'd0;
   assign bus.r1_rdata = bus.r1_ack ? rdata_q : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a big-endian memory model
module tb_dmem_arbiter;
   import dmem_pkg::*;

   logic clock = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;
   int   overlaps = 0;

   logic [31:0] mem [0:8191];
   logic [31:0] rd_word;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always #5 clock = ~clock;

   dmem_arbiter_if bus ();

   dmem_arbiter #(.MEM_BYTES(32768)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always_comb begin
      rd_word = mem[bus.mem_address[14:2]];
      rd_byte = 8'(rd_word >> {~bus.mem_address[1:0], 3'b000});
      rd_half = bus.mem_address[1] ? rd_word[15:0] : rd_word[31:16];
      case (bus.mem_lscontrol)
         2'd0:    bus.mem_readdata = bus.mem_sign_extend ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
         2'd1:    bus.mem_readdata = bus.mem_sign_extend ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
         default: bus.mem_readdata = rd_word;
      endcase
   end

   always @(posedge clock) begin
      if (bus.mem_memwrite) begin
         case (bus.mem_lscontrol)
            2'd0: mem[bus.mem_address[14:2]][{~bus.mem_address[1:0], 3'b000} +: 8] = bus.mem_writedata[7:0];
            2'd1: begin
               if (bus.mem_address[1]) mem[bus.mem_address[14:2]][15:0] = bus.mem_writedata[15:0];
               else                    mem[bus.mem_address[14:2]][31:16] = bus.mem_writedata[15:0];
            end
            default: mem[bus.mem_address[14:2]] = bus.mem_writedata;
         endcase
      end
   end

   always @(negedge clock) begin
      if (bus.mem_memread || bus.mem_memwrite) pulses++;
      if (bus.mem_memread && bus.mem_memwrite) overlaps++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input bit port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic sext,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                         input string tag);
      int          lat;
      logic        seen;
      logic        err;
      logic        other;
      logic [31:0] rdata;
      @(negedge clock);
      if (port) begin
         bus.r1_req = 1'b1; bus.r1_we = we; bus.r1_addr = addr;
         bus.r1_wdata = wdata; bus.r1_size = size; bus.r1_sext = sext;
      end else begin
         bus.r0_req = 1'b1; bus.r0_we = we; bus.r0_addr = addr;
         bus.r0_wdata = wdata; bus.r0_size = size; bus.r0_sext = sext;
      end
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 8) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
         seen = port ? bus.r1_ack : bus.r0_ack;
      end
      err   = port ? bus.r1_err   : bus.r0_err;
      rdata = port ? bus.r1_rdata : bus.r0_rdata;
      other = port ? bus.r0_ack   : bus.r1_ack;
      if (port) bus.r1_req = 1'b0;
      else      bus.r0_req = 1'b0;
      chk({tag, "_ack"},   32'(seen), 32'd1);
      chk({tag, "_lat"},   32'(lat), 32'(exp_lat));
      chk({tag, "_err"},   32'(err), 32'(exp_err));
      chk({tag, "_rdata"}, rdata, exp_rdata);
      chk({tag, "_other"}, 32'(other), 32'd0);
   endtask

   initial begin
      logic        got;
      int          cyc;
      int          acks;
      int          p0;
      logic [31:0] snap0, snap8, snap9;

      reset_n = 1'b0;
      bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0; bus.r0_size = '0; bus.r0_sext = 1'b0;
      bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0; bus.r1_size = '0; bus.r1_sext = 1'b0;

      @(negedge clock);
      chk("rst_r0_ack", 32'(bus.r0_ack), 32'd0);
      chk("rst_r1_ack", 32'(bus.r1_ack), 32'd0);
      chk("rst_r0_rdata", bus.r0_rdata, 32'd0);
      chk("rst_memread", 32'(bus.mem_memread), 32'd0);
      chk("rst_memwrite", 32'(bus.mem_memwrite), 32'd0);
      chk("rst_address", bus.mem_address, 32'd0);

      bus.r0_req = 1'b1; bus.r0_addr = 32'h0; bus.r0_size = LS_WORD;
      bus.r1_req = 1'b1; bus.r1_addr = 32'h4; bus.r1_size = LS_WORD;
      @(negedge clock);
      reset_n = 1'b1;
      for (int g = 0; g < 4; g++) begin
         got = 1'b0;
         cyc = 0;
         while (!got && cyc < 10) begin
            @(negedge clock);
            cyc++;
            got = bus.r0_ack | bus.r1_ack;
         end
         chk("tie_ack_seen", 32'(got), 32'd1);
         chk("tie_winner", 32'(bus.r1_ack), 32'(g % 2));
         chk("tie_single_ack", 32'(bus.r0_ack & bus.r1_ack), 32'd0);
      end
      bus.r0_req = 1'b0;
      bus.r1_req = 1'b0;

      do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, LS_WORD, 1'b0, 32'h0, 1'b0, 2, "st_w10");
      chk("mem_0x10", mem[4], 32'hDEADBEEF);
      do_req(1'b0, 1'b0, 32'h10, 32'h0, LS_WORD, 1'b0, 32'hDEADBEEF, 1'b0, 2, "ld_w10");

      do_req(1'b1, 1'b1, 32'h20, 32'h80FF7F01, LS_WORD, 1'b0, 32'h0, 1'b0, 2, "st_w20");
      do_req(1'b1, 1'b0, 32'h20, 32'h0, LS_BYTE, 1'b1, 32'hFFFFFF80, 1'b0, 2, "ld_b20_s");
      do_req(1'b1, 1'b0, 32'h20, 32'h0, LS_BYTE, 1'b0, 32'h00000080, 1'b0, 2, "ld_b20_u");
      do_req(1'b1, 1'b0, 32'h22, 32'h0, LS_HALF, 1'b1, 32'h00007F01, 1'b0, 2, "ld_h22_s");
      do_req(1'b1, 1'b0, 32'h21, 32'h0, LS_BYTE, 1'b1, 32'hFFFFFFFF, 1'b0, 2, "ld_b21_s");
      do_req(1'b1, 1'b1, 32'h21, 32'h000000AB, LS_BYTE, 1'b0, 32'h0, 1'b0, 2, "st_b21");
      chk("mem_0x20_byte", mem[8], 32'h80AB7F01);
      do_req(1'b0, 1'b0, 32'h20, 32'h0, LS_WORD, 1'b0, 32'h80AB7F01, 1'b0, 2, "ld_w20");

      snap0 = mem[0];
      snap8 = mem[8];
      snap9 = mem[9];
      p0 = pulses;
      do_req(1'b0, 1'b1, 32'h21, 32'hCAFEF00D, LS_HALF, 1'b0, 32'h0, 1'b1, 1, "ill_h21");
      do_req(1'b1, 1'b1, 32'h22, 32'hCAFEF00D, LS_WORD, 1'b0, 32'h0, 1'b1, 1, "ill_w22");
      do_req(1'b0, 1'b1, 32'h24, 32'hCAFEF00D, 2'd3,    1'b0, 32'h0, 1'b1, 1, "ill_sz3");
      do_req(1'b1, 1'b1, 32'h8000, 32'hCAFEF00D, LS_WORD, 1'b0, 32'h0, 1'b1, 1, "ill_8000");
      do_req(1'b0, 1'b0, 32'h8000, 32'h0, LS_WORD, 1'b0, 32'h0, 1'b1, 1, "ill_ld8000");
      chk("ill_no_pulse", 32'(pulses - p0), 32'd0);
      chk("ill_mem_0x20", mem[8], 32'h80AB7F01);
      chk("ill_mem_0x20_snap", mem[8], snap8);
      chk("ill_mem_0x24", mem[9], snap9);
      chk("ill_mem_0x00", mem[0], snap0);

      do_req(1'b0, 1'b1, 32'h40, 32'h0BADF00D, LS_WORD, 1'b0, 32'h0, 1'b0, 2, "st_w40");
      @(negedge clock);
      bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 32'h40;
      bus.r0_wdata = 32'h12345678; bus.r0_size = LS_WORD; bus.r0_sext = 1'b0;
      @(posedge clock);
      #2;
      chk("rst_mid_access_we", 32'(bus.mem_memwrite), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_we_low", 32'(bus.mem_memwrite), 32'd0);
      chk("rst_mid_no_ack", 32'(bus.r0_ack), 32'd0);
      chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
      @(posedge clock);
      #1;
      chk("rst_mid_mem_0x40", mem[16], 32'h0BADF00D);
      @(negedge clock);
      bus.r0_req = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      acks = 0;
      repeat (4) begin
         @(negedge clock);
         if (bus.r0_ack || bus.r1_ack) acks++;
      end
      chk("rst_mid_no_late_ack", 32'(acks), 32'd0);
      do_req(1'b0, 1'b1, 32'h40, 32'h12345678, LS_WORD, 1'b0, 32'h0, 1'b0, 2, "st_w40_retry");
      chk("retry_mem_0x40", mem[16], 32'h12345678);

      chk("no_dual_strobe", 32'(overlaps), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
